pmci_axil_csr_responder: RTL and testbench
==========================================

Name: pmci_axil_csr_responder

Overview:
- AXI4-lite responder (slave) that terminates requests issued by the PMCI subsystem's AXI master port.
- Implements a small PMCI-facing CSR block: DFH, scratchpad and a one-entry command mailbox toward FIM logic.
- Echoes AWID/ARID correctly as BID/RID. One outstanding transaction per direction; read and write channels are independent.

Parameters:
- ADDR_W, 20, AXI address width; decode uses addr[5:3], bits [2:0] ignored.
- FEAT_ID, 12'h013, DFH feature ID.
- FEAT_VER, 4'h1, DFH feature version.
- NEXT_DFH_OFFSET, 24'h1000, DFH next offset.
- END_OF_LIST, 1'b0, DFH EOL bit.

Ports:
- clk_csr  in  1  CSR clock; all logic single-clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- awid/awaddr/awprot/awvalid  in  8/ADDR_W/3/1  write address channel.
- awready  out  1  write address ready.
- wdata/wstrb/wvalid  in  64/8/1  write data channel.
- wready  out  1  write data ready.
- bid/bresp/bvalid  out  8/2/1  write response; bready in 1.
- arid/araddr/arprot/arvalid  in  8/ADDR_W/3/1  read address channel.
- arready  out  1  read address ready.
- rid/rdata/rresp/rvalid  out  8/64/2/1  read response; rready in 1.
- mbox_cmd  out  64  last value written to MBOX_CMD.
- mbox_pending  out  1  command awaiting FIM service.
- mbox_ack  in  1  single-cycle pulse from FIM; clears pending.

Behaviour:
- Register map (qword offsets):
  - 0x00 DFH RO = {4'h3, 19'h0, END_OF_LIST, NEXT_DFH_OFFSET, FEAT_VER, FEAT_ID}.
  - 0x08 SCRATCH RW, reset 0.
  - 0x10 MBOX_CMD RW, reset 0; any write sets pending.
  - 0x18 MBOX_STAT: [0] pending, write 1 to clear; [15:8] AWID of last MBOX_CMD write, RO; [63:32] MBOX_CMD write counter, RO, wraps 0xFFFFFFFF→0.
  - Any other offset: writes ignored with bresp=SLVERR (2'b10); reads return rdata=0, rresp=SLVERR.
- Byte strobes apply to RW registers only. A write with wstrb=0 is accepted with OKAY and changes nothing, including pending and the counter.
- Write FSM:
  - States W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_W; wready=1 in W_IDLE and W_HAVE_AW.
  - AW and W in the same cycle: W_IDLE→W_RESP.
  - AW only: →W_HAVE_AW, then →W_RESP when W arrives. W only: →W_HAVE_W, then →W_RESP when AW arrives.
  - Register update occurs on the cycle the FSM enters W_RESP. bvalid=1 from the next cycle, with bid = latched awid.
  - Hold bvalid until bready, then →W_IDLE. No new AW/W is accepted while in W_RESP.
- Read FSM:
  - States R_IDLE (arready=1) and R_RESP (rvalid=1).
  - AR handshake at cycle t → rvalid at t+1. rdata/rresp/rid are captured at the handshake and held stable until rready.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- mbox_ack in the same cycle as an MBOX_CMD write update: set wins (pending=1). W1C and ack together: pending=0.
- mbox_pending asserts the cycle after the MBOX_CMD update.
- Reset values: awready=wready=arready=0 during reset, then 1 the first cycle after release. bvalid=rvalid=0; bid/rid/bresp/rresp/rdata=0; mbox_cmd=0; mbox_pending=0; counter=0.
- Reset mid-transaction aborts it silently: no response is issued and no register is updated.

Decomposition:
- Package pmci_axil_csr_resp_pkg holds:
  - register offset constants;
  - RESP_OKAY/RESP_SLVERR;
  - write and read FSM state enums;
  - DFH field typedef.
- Sub-module pmci_axil_wr_join: AW/W join FSM plus address/ID/data latch, producing a single-cycle wr_req with addr/id/data/strb. Read path and register bank stay in the top module.

Test Plan:
- Read 0x00 with arid=0x5A, defaults → rvalid 1 cycle after handshake, rid=0x5A, rdata=0x3000_0000_1000_1013, rresp=OKAY.
- W at cycle 0, AW (awid=0x21, addr 0x08, wdata=0xDEAD_BEEF_0123_4567, wstrb=0x0F) at cycle 3 → bid=0x21, OKAY; read 0x08 → 0x0000_0000_0123_4567.
- Write MBOX_CMD=0x55 twice, with rready/bready held low 5 cycles → mbox_pending=1, mbox_cmd=0x55, STAT[63:32]=2, responses held stable while stalled.
- Write MBOX_CMD in the same cycle as an mbox_ack pulse → pending stays 1; write STAT=0x1 → pending=0.
- Read/write offset 0x20 → rresp=SLVERR, rdata=0, bresp=SLVERR; SCRATCH unchanged.
- Assert rst_n low while in W_HAVE_AW → no bvalid after release, SCRATCH=0, all ready signals=1 on the first cycle after release.

Source files
------------

// File: rtl/pmci_axil_csr_resp_pkg.sv
// rtl/pmci_axil_csr_resp_pkg.sv - shared constants, FSM states and DFH layout for the PMCI CSR responder
package pmci_axil_csr_resp_pkg;

   localparam logic [2:0] OFF_DFH       = 3'd0;
   localparam logic [2:0] OFF_SCRATCH   = 3'd1;
   localparam logic [2:0] OFF_MBOX_CMD  = 3'd2;
   localparam logic [2:0] OFF_MBOX_STAT = 3'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_t;

   typedef struct packed {
      logic [3:0]  feat_type;
      logic [18:0] rsvd;
      logic        eol;
      logic [23:0] next_off;
      logic [3:0]  feat_ver;
      logic [11:0] feat_id;
   } dfh_t;

   function automatic logic [63:0] apply_strb(input logic [63:0] cur,
                                              input logic [63:0] din,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = cur;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) res[i*8 +: 8] = din[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pmci_axil_wr_join.sv
// rtl/pmci_axil_wr_join.sv - joins AW and W beats into one write request and runs the B handshake
module pmci_axil_wr_join
   import pmci_axil_csr_resp_pkg::*;
#(
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [7:0]        bid,
   output logic              bvalid,
   input  logic              bready,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_id,
   output logic [63:0]       wr_data,
   output logic [7:0]        wr_strb
);

   wr_state_t state;
   logic      aw_fire;
   logic      w_fire;

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   // wr_req is high exactly during the first W_RESP cycle; the top commits on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= W_IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         wr_req  <= 1'b0;
         wr_addr <= '0;
         wr_id   <= '0;
         wr_data <= '0;
         wr_strb <= '0;
      end else begin
         wr_req <= 1'b0;
         if (aw_fire) begin
            wr_addr <= awaddr;
            wr_id   <= awid;
         end
         if (w_fire) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
         end
         case (state)
            W_IDLE: begin
               awready <= 1'b1;
               wready  <= 1'b1;
               if (aw_fire && w_fire) begin
                  state   <= W_RESP;
                  wr_req  <= 1'b1;
                  awready <= 1'b0;
                  wready  <= 1'b0;
               end else if (aw_fire) begin
                  state   <= W_HAVE_AW;
                  awready <= 1'b0;
               end else if (w_fire) begin
                  state  <= W_HAVE_W;
                  wready <= 1'b0;
               end
            end
            W_HAVE_AW: begin
               if (w_fire) begin
                  state  <= W_RESP;
                  wr_req <= 1'b1;
                  wready <= 1'b0;
               end
            end
            W_HAVE_W: begin
               if (aw_fire) begin
                  state   <= W_RESP;
                  wr_req  <= 1'b1;
                  awready <= 1'b0;
               end
            end
            W_RESP: begin
               if (wr_req) begin
                  bvalid <= 1'b1;
                  bid    <= wr_id;
               end else if (bvalid && bready) begin
                  bvalid  <= 1'b0;
                  state   <= W_IDLE;
                  awready <= 1'b1;
                  wready  <= 1'b1;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pmci_axil_csr_responder.sv
// rtl/pmci_axil_csr_responder.sv - AXI4-lite CSR responder: DFH, scratchpad and FIM command mailbox
module pmci_axil_csr_responder
   import pmci_axil_csr_resp_pkg::*;
#(
   parameter int          ADDR_W          = 20,
   parameter logic [11:0] FEAT_ID         = 12'h013,
   parameter logic [3:0]  FEAT_VER        = 4'h1,
   parameter logic [23:0] NEXT_DFH_OFFSET = 24'h1000,
   parameter logic        END_OF_LIST     = 1'b0
) (
   input  logic              clk_csr,
   input  logic              rst_n,
   input  logic [7:0]        awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [2:0]        awprot,
   input  logic              awvalid,
   output logic              awready,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [7:0]        bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [7:0]        arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [2:0]        arprot,
   input  logic              arvalid,
   output logic              arready,
   output logic [7:0]        rid,
   output logic [63:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   output logic [63:0]       mbox_cmd,
   output logic              mbox_pending,
   input  logic              mbox_ack
);

   localparam dfh_t DFH_VAL = '{
      feat_type: 4'h3,
      rsvd:      19'h0,
      eol:       END_OF_LIST,
      next_off:  NEXT_DFH_OFFSET,
      feat_ver:  FEAT_VER,
      feat_id:   FEAT_ID
   };

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_id;
   logic [63:0]       wr_data;
   logic [7:0]        wr_strb;

   logic [63:0] scratch;
   logic [7:0]  mbox_awid;
   logic [31:0] mbox_cnt;
   logic [2:0]  wr_off;
   logic        mbox_set;
   logic        stat_w1c;
   logic [63:0] rd_val;
   logic [1:0]  rd_resp;
   rd_state_t   rd_state;

   logic unused_bits;
   assign unused_bits = ^{awprot, arprot, araddr[ADDR_W-1:6], araddr[2:0],
                          wr_addr[ADDR_W-1:6], wr_addr[2:0]};

   pmci_axil_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
      .clk     (clk_csr),
      .rst_n   (rst_n),
      .awid    (awid),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bid     (bid),
      .bvalid  (bvalid),
      .bready  (bready),
      .wr_req  (wr_req),
      .wr_addr (wr_addr),
      .wr_id   (wr_id),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   assign wr_off   = wr_addr[5:3];
   assign mbox_set = wr_req && (wr_off == OFF_MBOX_CMD) && (wr_strb != 8'h00);
   assign stat_w1c = wr_req && (wr_off == OFF_MBOX_STAT) && wr_strb[0] && wr_data[0];

   always_ff @(posedge clk_csr or negedge rst_n) begin
      if (!rst_n) begin
         scratch      <= '0;
         mbox_cmd     <= '0;
         mbox_awid    <= '0;
         mbox_cnt     <= '0;
         mbox_pending <= 1'b0;
         bresp        <= RESP_OKAY;
      end else begin
         if (wr_req) begin
            bresp <= (wr_off <= OFF_MBOX_STAT) ? RESP_OKAY : RESP_SLVERR;
            if (wr_off == OFF_SCRATCH) scratch <= apply_strb(scratch, wr_data, wr_strb);
         end
         if (mbox_set) begin
            mbox_cmd  <= apply_strb(mbox_cmd, wr_data, wr_strb);
            mbox_awid <= wr_id;
            mbox_cnt  <= mbox_cnt + 32'd1;
         end
         // A fresh command outranks a simultaneous ack or W1C so it is never lost.
         if (mbox_set)                  mbox_pending <= 1'b1;
         else if (mbox_ack || stat_w1c) mbox_pending <= 1'b0;
      end
   end

   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_OKAY;
      case (araddr[5:3])
         OFF_DFH:       rd_val = DFH_VAL;
         OFF_SCRATCH:   rd_val = scratch;
         OFF_MBOX_CMD:  rd_val = mbox_cmd;
         OFF_MBOX_STAT: rd_val = {mbox_cnt, 16'h0, mbox_awid, 7'h0, mbox_pending};
         default:       rd_resp = RESP_SLVERR;
      endcase
   end

   // Read data is sampled at the AR handshake, so a same-cycle write is not yet visible.
   always_ff @(posedge clk_csr or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= R_IDLE;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rid      <= '0;
         rdata    <= '0;
         rresp    <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               arready <= 1'b1;
               if (arvalid && arready) begin
                  rid      <= arid;
                  rdata    <= rd_val;
                  rresp    <= rd_resp;
                  rvalid   <= 1'b1;
                  arready  <= 1'b0;
                  rd_state <= R_RESP;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid   <= 1'b0;
                  arready  <= 1'b1;
                  rd_state <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmci_axil_csr_responder.sv
// tb/tb_pmci_axil_csr_responder.sv - directed and randomized bench for pmci_axil_csr_responder
module tb_pmci_axil_csr_responder;

   logic        clk_csr = 1'b0;
   logic        rst_n   = 1'b1;
   logic [7:0]  awid = '0;
   logic [19:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [7:0]  arid = '0;
   logic [19:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [7:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [63:0] mbox_cmd;
   logic        mbox_pending;
   logic        mbox_ack = 1'b0;

   int passed = 0;
   int total  = 0;

   logic [63:0] m_scratch;
   logic [63:0] m_cmd;
   logic        m_pend;
   logic [7:0]  m_awid;
   logic [31:0] m_cnt;

   pmci_axil_csr_responder dut (
      .clk_csr(clk_csr), .rst_n(rst_n),
      .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .mbox_cmd(mbox_cmd), .mbox_pending(mbox_pending), .mbox_ack(mbox_ack)
   );

   always #5 clk_csr = ~clk_csr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_scratch = 64'h0; m_cmd = 64'h0; m_pend = 1'b0; m_awid = 8'h0; m_cnt = 32'h0;
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] strb);
      logic [63:0] mask = '0;
      for (int i = 0; i < 8; i++) if (strb[i]) mask = mask | (64'hFF << (8 * i));
      return (old & ~mask) | (nw & mask);
   endfunction

   task automatic model_write(input logic [19:0] addr, input logic [63:0] data, input logic [7:0] strb,
                              input logic [7:0] id, input bit ack, output logic [1:0] resp);
      int off = (int'(addr) / 8) % 8;
      bit set_p = 0;
      bit clr_p = ack;
      resp = (off < 4) ? 2'b00 : 2'b10;
      if (strb != 0) begin
         if (off == 1) m_scratch = merge(m_scratch, data, strb);
         if (off == 2) begin
            m_cmd = merge(m_cmd, data, strb); set_p = 1; m_awid = id; m_cnt = m_cnt + 1;
         end
         if (off == 3 && strb[0] && data[0]) clr_p = 1;
      end
      if (set_p) m_pend = 1'b1;
      else if (clr_p) m_pend = 1'b0;
   endtask

   task automatic model_read(input logic [19:0] addr, output logic [63:0] data, output logic [1:0] resp);
      int off = (int'(addr) / 8) % 8;
      resp = 2'b00;
      case (off)
         0: data = 64'h3000_0000_1000_1013;
         1: data = m_scratch;
         2: data = m_cmd;
         3: data = {m_cnt, 16'h0, m_awid, 7'h0, m_pend};
         default: begin data = 64'h0; resp = 2'b10; end
      endcase
   endtask

   task automatic axi_write(input logic [19:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input logic [7:0] id, input int aw_dly, input int w_dly, input int stall,
                            input bit ack);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int cyc = 0;
      logic [1:0] exp_resp;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && (cyc >= aw_dly); awaddr = addr; awid = id;
         wvalid  = !w_done && (cyc >= w_dly); wdata = data; wstrb = strb;
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(negedge clk_csr);
         aw_done = aw_done | aw_fire;
         w_done  = w_done | w_fire;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_handshake", {63'h0, aw_done && w_done}, 64'h1);
      model_write(addr, data, strb, id, ack, exp_resp);
      mbox_ack = ack;
      @(negedge clk_csr);
      mbox_ack = 1'b0;
      cyc = 1;
      while (!bvalid && cyc < 20) begin @(negedge clk_csr); cyc++; end
      chk("b_latency", 64'(cyc), 64'd1);
      chk("bid", {56'h0, bid}, {56'h0, id});
      chk("bresp", {62'h0, bresp}, {62'h0, exp_resp});
      chk("mbox_pending", {63'h0, mbox_pending}, {63'h0, m_pend});
      chk("mbox_cmd", mbox_cmd, m_cmd);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_csr);
         chk("b_hold", {54'h0, bvalid, bid, bresp}, {54'h0, 1'b1, id, exp_resp});
      end
      bready = 1'b1;
      @(negedge clk_csr);
      bready = 1'b0;
      chk("b_drop", {63'h0, bvalid}, 64'h0);
   endtask

   task automatic axi_read(input logic [19:0] addr, input logic [7:0] id, input int stall,
                           output logic [63:0] got);
      int cyc = 0;
      logic [63:0] exp_data;
      logic [1:0]  exp_resp;
      arvalid = 1'b1; araddr = addr; arid = id;
      while (!arready && cyc < 20) begin @(negedge clk_csr); cyc++; end
      model_read(addr, exp_data, exp_resp);
      @(negedge clk_csr);
      arvalid = 1'b0;
      chk("r_latency", {63'h0, rvalid}, 64'h1);
      chk("rid", {56'h0, rid}, {56'h0, id});
      chk("rdata", rdata, exp_data);
      chk("rresp", {62'h0, rresp}, {62'h0, exp_resp});
      got = rdata;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_csr);
         chk("r_hold", {rvalid, rid, rresp, rdata[52:0]}, {1'b1, id, exp_resp, exp_data[52:0]});
      end
      rready = 1'b1;
      @(negedge clk_csr);
      rready = 1'b0;
      chk("r_drop", {63'h0, rvalid}, 64'h0);
   endtask

   initial begin
      logic [63:0] got;
      logic [19:0] a;
      logic [7:0]  st;
      int          off;
      #2 rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_csr);
      chk("rst_ready", {61'h0, awready, wready, arready}, 64'h0);
      chk("rst_valid", {62'h0, bvalid, rvalid}, 64'h0);
      chk("rst_outs", {mbox_pending, bid, rid, bresp, rresp}, 64'h0);
      chk("rst_rdata", rdata, 64'h0);
      chk("rst_mbox_cmd", mbox_cmd, 64'h0);
      rst_n = 1'b1;
      @(negedge clk_csr);
      chk("post_rst_ready", {61'h0, awready, wready, arready}, 64'h7);

      axi_read(20'h00000, 8'h5A, 0, got);
      chk("dfh_value", got, 64'h3000_0000_1000_1013);

      axi_write(20'h00008, 64'hDEAD_BEEF_0123_4567, 8'h0F, 8'h21, 3, 0, 0, 1'b0);
      axi_read(20'h00008, 8'h33, 0, got);
      chk("scratch_strb", got, 64'h0000_0000_0123_4567);

      axi_write(20'h00010, 64'h55, 8'hFF, 8'h10, 0, 0, 5, 1'b0);
      axi_write(20'h00010, 64'h55, 8'hFF, 8'h11, 1, 0, 5, 1'b0);
      axi_read(20'h00018, 8'h44, 5, got);
      chk("mbox_count2", {32'h0, got[63:32]}, 64'd2);
      chk("mbox_cmd_55", mbox_cmd, 64'h55);
      chk("mbox_pend_set", {63'h0, mbox_pending}, 64'h1);

      axi_write(20'h00010, 64'h77, 8'h01, 8'h12, 0, 0, 0, 1'b1);
      chk("ack_vs_set", {63'h0, mbox_pending}, 64'h1);
      axi_write(20'h00018, 64'h1, 8'h01, 8'h13, 0, 2, 0, 1'b0);
      chk("w1c_clear", {63'h0, mbox_pending}, 64'h0);
      axi_write(20'h00010, 64'h99, 8'h00, 8'h14, 0, 0, 0, 1'b0);
      chk("strb0_no_pend", {63'h0, mbox_pending}, 64'h0);

      axi_read(20'h00020, 8'h66, 0, got);
      chk("bad_rd_data", got, 64'h0);
      axi_write(20'h00020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h67, 0, 0, 0, 1'b0);
      axi_read(20'h00008, 8'h68, 0, got);
      chk("scratch_kept", got, 64'h0000_0000_0123_4567);

      for (int n = 0; n < 40; n++) begin
         off = $urandom_range(0, 5);
         a = ($urandom & 20'hFFFC0) | 20'(off * 8) | 20'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            st = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            axi_write(a, {$urandom, $urandom}, st, 8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
         end else begin
            axi_read(a, 8'($urandom), $urandom_range(0, 2), got);
         end
      end

      awvalid = 1'b1; awaddr = 20'h00008; awid = 8'h7E;
      @(negedge clk_csr);
      awvalid = 1'b0;
      chk("have_aw_wready", {62'h0, awready, wready}, 64'h1);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk_csr);
      chk("mid_rst_ready", {61'h0, awready, wready, arready}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk_csr);
      chk("mid_rst_release", {61'h0, awready, wready, arready}, 64'h7);
      wvalid = 1'b1; wdata = 64'h1234; wstrb = 8'hFF;
      @(negedge clk_csr);
      wvalid = 1'b0;
      repeat (4) begin
         @(negedge clk_csr);
         chk("no_stale_b", {63'h0, bvalid}, 64'h0);
      end
      chk("orphan_w_wait", {62'h0, awready, wready}, 64'h2);
      axi_read(20'h00008, 8'h01, 0, got);
      chk("scratch_after_rst", got, 64'h0);
      chk("mbox_after_rst", {mbox_cmd[62:0], mbox_pending}, 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
